// File: rtl/tl_ul_ram_responder.sv
// rtl/tl_ul_ram_responder.sv - TL-UL word RAM responder with a 2-entry response queue
module tl_ul_ram_responder #(
    parameter int                ADDR_W = 32,
    parameter int                SRC_W  = 5,
    parameter int                DEPTH  = 256,
    parameter logic [ADDR_W-1:0] BASE   = 32'h0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [2:0]        a_opcode,
    input  logic [2:0]        a_param,
    input  logic [3:0]        a_size,
    input  logic [SRC_W-1:0]  a_source,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [3:0]        a_mask,
    input  logic [31:0]       a_data,
    output logic              d_valid,
    input  logic              d_ready,
    output logic [2:0]        d_opcode,
    output logic [1:0]        d_param,
    output logic [3:0]        d_size,
    output logic [SRC_W-1:0]  d_source,
    output logic              d_sink,
    output logic              d_denied,
    output logic [31:0]       d_data,
    output logic              d_corrupt
);
    localparam int         IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_GET      = 3'd4;

    typedef struct packed {
        logic             is_get;
        logic [3:0]       size;
        logic [SRC_W-1:0] source;
        logic             denied;
        logic [31:0]      data;
    } rsp_t;

    logic [31:0] mem_q [DEPTH];
    rsp_t        ent_q [2];
    rsp_t        ent_d [2];
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;

    logic              a_fire, d_fire;
    logic              below_base;
    logic [ADDR_W-1:0] offset, word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              is_get, is_put, denied;
    rsp_t              new_rsp, head;
    logic              unused_a_param;

    assign unused_a_param = ^a_param;

    assign a_ready = !reset && (count_q != 2'd2);
    assign d_valid = !reset && (count_q != 2'd0);
    assign a_fire  = a_valid && a_ready;
    assign d_fire  = d_valid && d_ready;

    // The borrow out of the subtraction flags addresses below the window.
    always_comb begin
        {below_base, offset} = {1'b0, a_address} - {1'b0, BASE};
        word_idx = offset >> 2;
        mem_idx  = word_idx[IDX_W-1:0];
        is_get   = (a_opcode == OP_GET);
        is_put   = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART);
        denied   = below_base
                || (word_idx >= ADDR_W'(DEPTH))
                || (a_size > 4'd2)
                || ((a_size == 4'd1) && a_address[0])
                || ((a_size == 4'd2) && (a_address[1:0] != 2'b00))
                || !(is_get || is_put);
        new_rsp.is_get = is_get;
        new_rsp.size   = a_size;
        new_rsp.source = a_source;
        new_rsp.denied = denied;
        new_rsp.data   = (is_get && !denied) ? mem_q[mem_idx] : 32'h0;
    end

    always_comb begin
        ent_d    = ent_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (a_fire) begin
            ent_d[wr_ptr_q] = new_rsp;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (d_fire) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({a_fire, d_fire})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            ent_q[0] <= '0;
            ent_q[1] <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ent_q    <= ent_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clock) begin
        if (a_fire && is_put && !denied) begin
            for (int i = 0; i < 4; i++) begin
                if (a_mask[i]) begin
                    mem_q[mem_idx][8*i +: 8] <= a_data[8*i +: 8];
                end
            end
        end
    end

    assign head      = ent_q[rd_ptr_q];
    assign d_opcode  = d_valid ? {2'b00, head.is_get} : 3'd0;
    assign d_param   = 2'b00;
    assign d_size    = d_valid ? head.size : 4'd0;
    assign d_source  = d_valid ? head.source : '0;
    assign d_sink    = 1'b0;
    assign d_denied  = d_valid && head.denied;
    assign d_data    = d_valid ? head.data : 32'h0;
    assign d_corrupt = d_valid && head.is_get && head.denied;
endmodule
